// File: rtl/pixy_reset_pkg.sv
// Types and default timing constants shared by the CPU reset monitor and the reset generator.
package pixy_reset_pkg;

    typedef enum logic [2:0] {
        StBlank,
        StIdle,
        StRstChk,
        StPeriph,
        StHaltChk,
        StReboot
    } mon_state_e;

    localparam int unsigned SyncStagesDef  = 2;
    localparam int unsigned BlankCyclesDef = 64;
    localparam int unsigned RstQualDef     = 8;
    localparam int unsigned HaltQualDef    = 16;
    localparam int unsigned PeriphHoldDef  = 32;
    localparam int unsigned EventCountW    = 8;

endpackage

// File: rtl/cpu_reset_monitor_if.sv
// Pin and status bundle between the 68000 reset/halt pins, the reset generator and the monitor.
interface cpu_reset_monitor_if;

    logic       CPU_RESET_N;
    logic       CPU_HALT_N;
    logic       REBOOT_ACK;
    logic       PERIPH_RESET;
    logic       REBOOT_REQ;
    logic       FAULT;
    logic [7:0] EVENT_COUNT;

    modport master (
        output CPU_RESET_N,
        output CPU_HALT_N,
        output REBOOT_ACK,
        input  PERIPH_RESET,
        input  REBOOT_REQ,
        input  FAULT,
        input  EVENT_COUNT
    );

    modport slave (
        input  CPU_RESET_N,
        input  CPU_HALT_N,
        input  REBOOT_ACK,
        output PERIPH_RESET,
        output REBOOT_REQ,
        output FAULT,
        output EVENT_COUNT
    );

endinterface

// File: rtl/pin_qualifier.sv
// Synchronizes one open-drain pin and counts consecutive low samples while enabled;
// qual_o flags the sample that is the QUAL-th (or later) consecutive low.
module pin_qualifier #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned QUAL        = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pin_n_i,
    input  logic en_i,
    output logic level_o,
    output logic qual_o
);

    localparam int unsigned CW = $clog2(QUAL + 1);
    localparam logic [CW-1:0] QualLast = CW'(QUAL - 1);
    localparam logic [CW-1:0] QualMax  = CW'(QUAL);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_d, cnt_q;
    logic                   low_run;

    // Preset to 1 so a released (pulled-up) pin is assumed until proven otherwise.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '1;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_n_i};
            cnt_q  <= cnt_d;
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign low_run = en_i && !level_o;

    always_comb begin
        cnt_d = '0;
        if (low_run) begin
            cnt_d = (cnt_q == QualMax) ? cnt_q : cnt_q + CW'(1);
        end
    end

    assign qual_o = low_run && (cnt_q >= QualLast);

endmodule

// File: rtl/cpu_reset_monitor.sv
// Watches the 68000 /RESET and /HALT pins: stretches RESET instructions into PERIPH_RESET and
// turns a double bus fault into a cold-restart request. CPU_RESET_MON_EVENT_COUNT_EN builds EVENT_COUNT.
module cpu_reset_monitor
    import pixy_reset_pkg::*;
#(
    parameter int unsigned SYNC_STAGES  = SyncStagesDef,
    parameter int unsigned BLANK_CYCLES = BlankCyclesDef,
    parameter int unsigned RST_QUAL     = RstQualDef,
    parameter int unsigned HALT_QUAL    = HaltQualDef,
    parameter int unsigned PERIPH_HOLD  = PeriphHoldDef
) (
    input  logic                MCLK_IN,
    input  logic                RESET,
    cpu_reset_monitor_if.slave  bus
);

    localparam int unsigned BW = $clog2(BLANK_CYCLES + 1);
    localparam int unsigned HW = $clog2(PERIPH_HOLD + 1);
    localparam logic [BW-1:0] BlankLast = BW'(BLANK_CYCLES - 1);
    localparam logic [HW-1:0] HoldLast  = HW'(PERIPH_HOLD - 1);

    mon_state_e    state_q;
    logic [BW-1:0] blank_q;
    logic [HW-1:0] hold_q;
    logic          periph_q, req_q, fault_q;
    logic          rst_lvl, rst_qual, rst_en;
    logic          halt_lvl, halt_qual, halt_en;

    assign rst_en  = (state_q == StIdle) || (state_q == StRstChk) || (state_q == StHaltChk);
    // A halt only counts as a fault while /RESET is released.
    assign halt_en = ((state_q == StIdle) || (state_q == StHaltChk)) && rst_lvl;

    pin_qualifier #(
        .SYNC_STAGES (SYNC_STAGES),
        .QUAL        (RST_QUAL)
    ) u_rst_qual (
        .clk_i   (MCLK_IN),
        .rst_i   (RESET),
        .pin_n_i (bus.CPU_RESET_N),
        .en_i    (rst_en),
        .level_o (rst_lvl),
        .qual_o  (rst_qual)
    );

    pin_qualifier #(
        .SYNC_STAGES (SYNC_STAGES),
        .QUAL        (HALT_QUAL)
    ) u_halt_qual (
        .clk_i   (MCLK_IN),
        .rst_i   (RESET),
        .pin_n_i (bus.CPU_HALT_N),
        .en_i    (halt_en),
        .level_o (halt_lvl),
        .qual_o  (halt_qual)
    );

    always_ff @(posedge MCLK_IN) begin
        if (RESET) begin
            state_q  <= StBlank;
            blank_q  <= '0;
            hold_q   <= '0;
            periph_q <= 1'b0;
            req_q    <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StBlank: begin
                    if (blank_q == BlankLast) begin
                        state_q <= StIdle;
                        blank_q <= '0;
                    end else begin
                        blank_q <= blank_q + BW'(1);
                    end
                end
                StIdle: begin
                    if (!rst_lvl) begin
                        state_q <= StRstChk;
                    end else if (!halt_lvl) begin
                        state_q <= StHaltChk;
                    end
                end
                StRstChk: begin
                    if (rst_lvl) begin
                        state_q <= StIdle;
                    end else if (rst_qual) begin
                        state_q  <= StPeriph;
                        periph_q <= 1'b1;
                        hold_q   <= '0;
                    end
                end
                StPeriph: begin
                    if (!rst_lvl) begin
                        hold_q <= '0;
                    end else if (hold_q == HoldLast) begin
                        state_q  <= StIdle;
                        periph_q <= 1'b0;
                        hold_q   <= '0;
                    end else begin
                        hold_q <= hold_q + HW'(1);
                    end
                end
                StHaltChk: begin
                    if (!rst_lvl) begin
                        state_q <= StRstChk;
                    end else if (halt_lvl) begin
                        state_q <= StIdle;
                    end else if (halt_qual) begin
                        state_q <= StReboot;
                        fault_q <= 1'b1;
                        req_q   <= 1'b1;
                    end
                end
                StReboot: begin
                    if (bus.REBOOT_ACK) begin
                        state_q <= StBlank;
                        req_q   <= 1'b0;
                        blank_q <= '0;
                    end
                end
                default: state_q <= StBlank;
            endcase
        end
    end

    assign bus.PERIPH_RESET = periph_q;
    assign bus.REBOOT_REQ   = req_q;
    assign bus.FAULT        = fault_q;

`ifdef CPU_RESET_MON_EVENT_COUNT_EN
    logic [EventCountW-1:0] evt_q;
    logic                   evt_inc;

    assign evt_inc = (state_q == StRstChk) && rst_qual;

    always_ff @(posedge MCLK_IN) begin
        if (RESET) begin
            evt_q <= '0;
        end else if (evt_inc && (evt_q != '1)) begin
            evt_q <= evt_q + EventCountW'(1);
        end
    end

    assign bus.EVENT_COUNT = evt_q;
`else
    assign bus.EVENT_COUNT = 8'd0;
`endif

endmodule
